buff_diff_tracker: RTL and testbench

- Tracks fill level of the HPS-side DDR event ring buffer.
- Counts committed writes from the event writer, compares against the read pointer the HPS publishes through a PIO output, and packs level/flags into a 32-bit status word.
- Status word drives the in_port of the buff_diff_out PIO; its edge capture on bits 31/30/29/19 raises HPS interrupts.
- Also backpressures the writer when the ring is full.

---
 rtl/buff_diff_pkg.sv | 20 ++
 rtl/buff_idle_timer.sv | 29 ++
 rtl/buff_diff_tracker.sv | 99 +++++++++
 tb/tb_buff_diff_tracker.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/buff_diff_pkg.sv
// rtl/buff_diff_pkg.sv - status word layout and shared widths for the ring fill tracker
package buff_diff_pkg;

  localparam int WM_BIT    = 31;
  localparam int OVF_BIT   = 30;
  localparam int ERR_BIT   = 29;
  localparam int FULL_BIT  = 28;
  localparam int DROP_LSB  = 20;
  localparam int IDLE_BIT  = 19;
  localparam int EMPTY_BIT = 18;
  localparam int DIFF_W    = 17;

  localparam int DROP_W    = 8;
  localparam int PTR_W_MAX = 16;

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  typedef logic [31:0] status_t;

endpackage

// File: rtl/buff_idle_timer.sv
// rtl/buff_idle_timer.sv - saturating idle counter, expired once TIMEOUT clocks pass without a clear
module buff_idle_timer #(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/buff_diff_tracker.sv
// rtl/buff_diff_tracker.sv - write pointer, fill level and packed status word for the HPS event ring
module buff_diff_tracker #(
  parameter int PTR_W   = 12,
  parameter int TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_strobe,
  output logic             wr_ready,
  input  logic [PTR_W:0]   rd_ptr,
  input  logic [PTR_W:0]   thresh,
  input  logic             clr_sticky,
  output logic [PTR_W:0]   wr_ptr,
  output logic [31:0]      buff_diff_out
);

  import buff_diff_pkg::*;

  localparam logic [PTR_W:0] DEPTH = {1'b1, {PTR_W{1'b0}}};

  logic [PTR_W:0]     r_wr_ptr;
  logic               r_ovf;
  logic               r_err;
  logic [DROP_W-1:0]  r_drop;
  status_t            r_status;

  logic [PTR_W:0]     w_diff;
  logic               w_bad;
  logic               w_full;
  logic               w_empty;
  logic               w_accept;
  logic               w_drop;
  logic               w_wm;
  logic               w_idle;
  status_t            w_status;

  // Any distance beyond DEPTH means the HPS pointer is ahead of us: treat as full.
  assign w_diff   = r_wr_ptr - rd_ptr;
  assign w_bad    = (w_diff > DEPTH);
  assign w_full   = (w_diff == DEPTH) || w_bad;
  assign w_empty  = (w_diff == '0);
  assign w_accept = wr_strobe && !w_full;
  assign w_drop   = wr_strobe && w_full;
  assign w_wm     = (thresh != '0) && (w_diff >= thresh) && !w_bad;

  assign wr_ready      = !w_full;
  assign wr_ptr        = r_wr_ptr;
  assign buff_diff_out = r_status;

  buff_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (w_accept || w_empty),
    .i_enable  (!w_empty),
    .o_expired (w_idle)
  );

  always_comb begin
    w_status                          = '0;
    w_status[WM_BIT]                  = w_wm;
    w_status[OVF_BIT]                 = r_ovf;
    w_status[ERR_BIT]                 = r_err;
    w_status[FULL_BIT]                = w_full;
    w_status[DROP_LSB +: DROP_W]      = r_drop;
    w_status[IDLE_BIT]                = w_idle;
    w_status[EMPTY_BIT]               = w_empty;
    w_status[DIFF_W-1:0]              = DIFF_W'(w_diff);
  end

  // Set events beat a concurrent clr_sticky so no drop goes unrecorded.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
      r_drop   <= '0;
      r_status <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      end
      r_ovf <= w_drop || (r_ovf && !clr_sticky);
      r_err <= w_bad  || (r_err && !clr_sticky);
      if (w_drop) begin
        if (clr_sticky) begin
          r_drop <= DROP_W'(1);
        end else if (r_drop != DROP_MAX) begin
          r_drop <= r_drop + DROP_W'(1);
        end
      end else if (clr_sticky) begin
        r_drop <= '0;
      end
      r_status <= w_status;
    end
  end

endmodule

// File: tb/tb_buff_diff_tracker.sv
// tb/tb_buff_diff_tracker.sv - scoreboard bench for buff_diff_tracker with PTR_W=4, TIMEOUT=8
module tb_buff_diff_tracker;

  localparam int PTR_W   = 4;
  localparam int TIMEOUT = 8;

  localparam int K_STAT = 0;
  localparam int K_PTR  = 1;
  localparam int K_RDY  = 2;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             wr_strobe = 1'b0;
  logic             clr_sticky = 1'b0;
  logic [PTR_W:0]   rd_ptr = '0;
  logic [PTR_W:0]   thresh = 5'd10;
  logic             wr_ready;
  logic [PTR_W:0]   wr_ptr;
  logic [31:0]      buff_diff_out;

  exp_t        q[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;
  exp_t        m_e;
  logic [31:0] m_act;

  buff_diff_tracker #(
    .PTR_W   (PTR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_strobe     (wr_strobe),
    .wr_ready      (wr_ready),
    .rd_ptr        (rd_ptr),
    .thresh        (thresh),
    .clr_sticky    (clr_sticky),
    .wr_ptr        (wr_ptr),
    .buff_diff_out (buff_diff_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      case (m_e.kind)
        K_STAT:  m_act = buff_diff_out;
        K_PTR:   m_act = 32'(wr_ptr);
        default: m_act = 32'(wr_ready);
      endcase
      n_vec++;
      if (m_e.cyc != cyc || m_act !== m_e.val) begin
        n_miss++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d/%0d)",
                 m_e.name, m_act, m_e.val, cyc, m_e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    wr_strobe  = 1'b0;
    clr_sticky = 1'b0;
    rd_ptr     = '0;
    tick();
    tick();
    reset_n    = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    chk(K_STAT, 32'h0000_0000, "reset_status");
    chk(K_PTR,  32'd0,         "reset_wr_ptr");
    chk(K_RDY,  32'd1,         "reset_wr_ready");

    // Ten writes up to the watermark threshold.
    wr_strobe = 1'b1;
    repeat (10) tick();
    wr_strobe = 1'b0;
    chk(K_PTR,  32'd10,        "t1_wr_ptr");
    chk(K_STAT, 32'h0000_0009, "t1_pre_watermark");
    tick();
    chk(K_STAT, 32'h8000_000A, "t1_watermark");

    // Fill to DEPTH, then three drops.
    do_reset();
    wr_strobe = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      tick();
      chk(K_PTR, (i < 16) ? 32'(i) : 32'd16, $sformatf("t2_wr_ptr_%0d", i));
      chk(K_RDY, (i < 16) ? 32'd1 : 32'd0,   $sformatf("t2_wr_ready_%0d", i));
    end
    chk(K_STAT, 32'hD020_0010, "t2_drop2");
    wr_strobe = 1'b0;
    tick();
    chk(K_STAT, 32'hD030_0010, "t2_drop3");

    // Strobe while full is dropped; the HPS then drains the ring.
    wr_strobe = 1'b1;
    chk(K_RDY, 32'd0, "t3_full_ready");
    tick();
    chk(K_STAT, 32'hD030_0010, "t3_status_full");
    chk(K_PTR,  32'd16,        "t3_strobe_dropped");
    wr_strobe = 1'b0;
    rd_ptr    = 5'd16;
    chk(K_RDY, 32'd1, "t3_ready_after_drain");
    tick();
    chk(K_STAT, 32'h4044_0000, "t3_empty");
    wr_strobe = 1'b1;
    tick();
    wr_strobe = 1'b0;
    chk(K_PTR, 32'd17, "t3_wr_ptr");
    tick();
    chk(K_STAT, 32'h4040_0001, "t3_diff1");

    // HPS pointer ahead of the writer.
    do_reset();
    wr_strobe = 1'b1;
    repeat (3) tick();
    wr_strobe = 1'b0;
    rd_ptr    = 5'd5;
    chk(K_RDY, 32'd0, "t4_bad_ready");
    tick();
    chk(K_STAT, 32'h1000_001E, "t4_full_bad");
    tick();
    chk(K_STAT, 32'h3000_001E, "t4_ptr_error");
    rd_ptr     = 5'd3;
    clr_sticky = 1'b1;
    chk(K_RDY, 32'd1, "t4_ready_restored");
    tick();
    clr_sticky = 1'b0;
    chk(K_STAT, 32'h2004_0000, "t4_error_pending");
    tick();
    chk(K_STAT, 32'h0004_0000, "t4_error_cleared");

    // Idle timer after two writes.
    wr_strobe = 1'b1;
    repeat (2) tick();
    wr_strobe = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk(K_STAT, (k >= 9) ? 32'h0008_0002 : 32'h0000_0002, $sformatf("t5_idle_%0d", k));
    end
    wr_strobe = 1'b1;
    tick();
    wr_strobe = 1'b0;
    chk(K_STAT, 32'h0008_0002, "t5_idle_at_write");
    tick();
    chk(K_STAT, 32'h0000_0003, "t5_idle_cleared");

    // Drop counter saturation and clear/set collision.
    do_reset();
    wr_strobe = 1'b1;
    for (int e = 1; e <= 276; e++) begin
      tick();
      if (e == 20 || e == 270 || e == 271 || e == 272 || e == 276) begin
        int d;
        d = (e - 17 > 255) ? 255 : e - 17;
        chk(K_STAT, 32'hD000_0010 | ((e >= 25) ? 32'h0008_0000 : 32'h0) | (32'(d) << 20),
            $sformatf("t6_drop_edge_%0d", e));
      end
    end
    clr_sticky = 1'b1;
    tick();
    chk(K_STAT, 32'hDFF8_0010, "t6_clr_with_drop_pre");
    clr_sticky = 1'b0;
    wr_strobe  = 1'b0;
    tick();
    chk(K_STAT, 32'hD018_0010, "t6_clr_with_drop");
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk(K_STAT, 32'hD018_0010, "t6_clr_only_pre");
    tick();
    chk(K_STAT, 32'h9008_0010, "t6_clr_only");
    thresh = '0;
    tick();
    chk(K_STAT, 32'h1008_0010, "t6_watermark_disabled");

    repeat (3) tick();
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d unchecked expectations, expected 0", q.size());
      n_vec  += q.size();
      n_miss += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
